irq_ctrl: RTL and testbench

Machine-mode external interrupt controller for the pipelined RISC-V core. It latches edge-triggered requests from `NSRC` peripheral sources, masks them with a software enable register, and selects the lowest-numbered pending source. It drives the exception unit's `interrupt` input and tracks the in-service source through a claim/complete handshake, so that at most one external interrupt is outstanding at a time.

---
 rtl/irq_ctrl_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 127 ++++++++++++
 tb/tb_irq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register map,
// FSM state encoding and the machine external interrupt cause value.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_ENABLE   = 2'd0;
    localparam logic [1:0] IRQ_PENDING  = 2'd1;
    localparam logic [1:0] IRQ_CLAIM    = 2'd2;
    localparam logic [1:0] IRQ_COMPLETE = 2'd3;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_CLAIMED = 1'b1
    } irq_state_e;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000000b;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder over the masked pending vector.
module irq_prio_enc #(
    parameter int NSRC = 8,
    parameter int IDW  = 5
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [IDW-1:0]  id
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                id  = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode external interrupt controller: edge-latched pending bits,
// enable mask, lowest-index arbitration and a claim/complete handshake.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            trap_ack,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic            irq_out,
    output logic [IDW-1:0]  irq_id
);

    irq_state_e      state_reg, state_next;
    logic [NSRC-1:0] src_q_reg;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] enable_reg, enable_next;
    logic            irq_out_reg, irq_out_next;
    logic [IDW-1:0]  irq_id_reg, irq_id_next;

    logic [NSRC-1:0] fire;
    logic [NSRC-1:0] w1c_mask;
    logic [NSRC-1:0] claim_mask;
    logic [NSRC-1:0] req;
    logic            claim;
    logic            complete_wr;
    logic            any;
    logic [IDW-1:0]  winner;
    logic            unused_wdata;

    assign fire        = irq_src & ~src_q_reg;
    assign w1c_mask    = (cfg_we && cfg_addr == IRQ_PENDING) ? cfg_wdata[NSRC-1:0] : '0;
    assign complete_wr = cfg_we && cfg_addr == IRQ_COMPLETE;
    assign enable_next = (cfg_we && cfg_addr == IRQ_ENABLE) ? cfg_wdata[NSRC-1:0] : enable_reg;
    assign unused_wdata = ^cfg_wdata[31:NSRC];

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_claim
            assign claim_mask[gi] = claim && (irq_id_reg == IDW'(gi));
        end
    endgenerate

    // A fire beats a clear landing in the same cycle.
    assign pending_next = (pending_reg & ~w1c_mask & ~claim_mask) | fire;

    // Arbitrate on this cycle's enable/clear writes so masking and unmasking
    // take effect on irq_out one cycle later; new fires wait for PENDING.
    assign req = pending_reg & ~w1c_mask & enable_next;

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .req (req),
        .any (any),
        .id  (winner)
    );

    always_comb begin
        state_next   = state_reg;
        irq_out_next = irq_out_reg;
        irq_id_next  = irq_id_reg;
        claim        = 1'b0;
        unique case (state_reg)
            IRQ_IDLE: begin
                if (trap_ack && irq_out_reg) begin
                    claim        = 1'b1;
                    irq_out_next = 1'b0;
                    state_next   = IRQ_CLAIMED;
                end else begin
                    irq_out_next = any;
                    irq_id_next  = winner;
                end
            end
            IRQ_CLAIMED: begin
                irq_out_next = 1'b0;
                if (complete_wr) begin
                    state_next   = IRQ_IDLE;
                    irq_out_next = any;
                    irq_id_next  = winner;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IRQ_IDLE;
            src_q_reg   <= '0;
            pending_reg <= '0;
            enable_reg  <= '0;
            irq_out_reg <= 1'b0;
            irq_id_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            src_q_reg   <= irq_src;
            pending_reg <= pending_next;
            enable_reg  <= enable_next;
            irq_out_reg <= irq_out_next;
            irq_id_reg  <= irq_id_next;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            IRQ_ENABLE:   cfg_rdata[NSRC-1:0] = enable_reg;
            IRQ_PENDING:  cfg_rdata[NSRC-1:0] = pending_reg;
            IRQ_CLAIM: begin
                cfg_rdata[31]      = (state_reg == IRQ_CLAIMED);
                cfg_rdata[IDW-1:0] = irq_id_reg;
            end
            IRQ_COMPLETE: cfg_rdata = '0;
        endcase
    end

    assign irq_out = irq_out_reg;
    assign irq_id  = irq_id_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: reset, priority, claim/complete,
// masking, set/clear collision, stray events and reset during a claim.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        trap_ack;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_out;
    logic [4:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl #(.NSRC(8), .IDW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .trap_ack  (trap_ack),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_out   (irq_out),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        cfg_we   = 1'b0;
        cfg_addr = addr;
        #1;
        chk(tag, cfg_rdata, exp);
        $display("rd   addr=%0d data=%h (%s)", addr, cfg_rdata, tag);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        $display("wr   addr=%0d data=%h", addr, data);
        step();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic ack();
        trap_ack = 1'b1;
        $display("ack  irq_out=%0b irq_id=%0d", irq_out, irq_id);
        step();
        trap_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = 8'hFF; trap_ack = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;

        // Reset with all sources high
        step(); step();
        rd(2'd0, 32'h0, "rst_enable");
        rd(2'd1, 32'h0, "rst_pending");
        rd(2'd2, 32'h0, "rst_claim");
        rd(2'd3, 32'h0, "rst_complete");
        chk("rst_irq_out", 32'(irq_out), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        rst = 1'b0;
        step();
        rd(2'd1, 32'hFF, "post_rst_pending");
        chk("post_rst_irq_out_masked", 32'(irq_out), 32'h0);
        wr(2'd0, 32'h01);
        chk("en0_irq_out", 32'(irq_out), 32'h1);
        chk("en0_irq_id", 32'(irq_id), 32'h0);
        rd(2'd0, 32'h01, "en0_enable");
        wr(2'd1, 32'hFF);
        chk("w1c_drop_irq_out", 32'(irq_out), 32'h0);
        rd(2'd1, 32'h0, "w1c_pending");
        irq_src = 8'h00;
        step();

        // Priority: sources 5 and 2 together
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'hFF, "enable_upper_bits");
        irq_src = 8'h24;
        step();
        irq_src = 8'h00;
        rd(2'd1, 32'h24, "prio_pending");
        chk("prio_irq_out_c1", 32'(irq_out), 32'h0);
        step();
        chk("prio_irq_out_c2", 32'(irq_out), 32'h1);
        chk("prio_irq_id", 32'(irq_id), 32'h2);
        ack();
        rd(2'd1, 32'h20, "claim_pending");
        rd(2'd2, 32'h8000_0002, "claim_read");
        chk("claim_irq_out", 32'(irq_out), 32'h0);
        wr(2'd2, 32'h0000_001F);
        rd(2'd2, 32'h8000_0002, "claim_write_ignored");

        // Complete hands over to source 5
        wr(2'd3, 32'hDEAD_BEEF);
        chk("cmpl_irq_out", 32'(irq_out), 32'h1);
        chk("cmpl_irq_id", 32'(irq_id), 32'h5);
        rd(2'd2, 32'h0000_0005, "cmpl_claim_read");

        // Re-fire of the claimed source while CLAIMED
        ack();
        rd(2'd1, 32'h0, "claim5_pending");
        irq_src = 8'h20;
        step();
        irq_src = 8'h00;
        rd(2'd1, 32'h20, "refire_pending");
        chk("refire_irq_out_held", 32'(irq_out), 32'h0);
        wr(2'd3, 32'h0);
        chk("refire_irq_out", 32'(irq_out), 32'h1);
        chk("refire_irq_id", 32'(irq_id), 32'h5);
        wr(2'd1, 32'h20);
        chk("refire_clear_irq_out", 32'(irq_out), 32'h0);

        // Mask
        wr(2'd0, 32'h0);
        irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        step();
        rd(2'd1, 32'h08, "mask_pending");
        chk("mask_irq_out", 32'(irq_out), 32'h0);
        wr(2'd0, 32'h08);
        chk("unmask_irq_out", 32'(irq_out), 32'h1);
        chk("unmask_irq_id", 32'(irq_id), 32'h3);

        // Fire and W1C of the same bit in one cycle
        irq_src = 8'h10;
        wr(2'd1, 32'h10);
        rd(2'd1, 32'h18, "collision_pending");
        chk("collision_irq_id", 32'(irq_id), 32'h3);

        // Stray trap_ack and stray COMPLETE in IDLE
        wr(2'd1, 32'hFF);
        irq_src = 8'h00;
        chk("stray_prep_irq_out", 32'(irq_out), 32'h0);
        irq_src = 8'h40;
        step();
        irq_src = 8'h00;
        rd(2'd1, 32'h40, "stray_pending");
        ack();
        rd(2'd1, 32'h40, "stray_ack_pending");
        rd(2'd2, 32'h0, "stray_ack_claim");
        wr(2'd3, 32'h0);
        rd(2'd1, 32'h40, "stray_cmpl_pending");
        rd(2'd2, 32'h0, "stray_cmpl_claim");
        chk("stray_cmpl_irq_out", 32'(irq_out), 32'h0);

        // Reset during a claim
        wr(2'd0, 32'h40);
        chk("c6_irq_out", 32'(irq_out), 32'h1);
        ack();
        rd(2'd2, 32'h8000_0006, "c6_claim_read");
        rst = 1'b1;
        #1;
        chk("midrst_irq_id", 32'(irq_id), 32'h0);
        chk("midrst_irq_out", 32'(irq_out), 32'h0);
        rd(2'd2, 32'h0, "midrst_claim");
        rd(2'd1, 32'h0, "midrst_pending");
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
